// File: rtl/key_click_decoder.sv
// Key gesture classifier: single click, double click and long press from a debounced key level.
// Optional KEY_CLICK_CNT_EN adds a 16-bit wrapping count of emitted events on click_cnt.
module key_click_decoder #(
  parameter int unsigned LONG_CYC = 12000000,
  parameter int unsigned DBL_CYC  = 15000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keyin,
  output logic        single_evt,
  output logic        double_evt,
  output logic        long_evt,
  output logic        busy
`ifdef KEY_CLICK_CNT_EN
  ,
  output logic [15:0] click_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StHold,
    StWait2,
    StPress2
  } state_e;

  localparam logic [31:0] LongLast = 32'(LONG_CYC - 1);
  localparam logic [31:0] DblLast  = 32'(DBL_CYC - 1);

  state_e      state_q;
  logic [31:0] timer_q;
  logic [31:0] timer_inc;
  logic        key_q;
  logic        armed_q;
  logic        press_edge;
  logic        release_edge;

  // armed_q blocks a key that was already low at reset from looking like a fresh press.
  assign press_edge   = armed_q & key_q & ~keyin;
  assign release_edge = ~key_q & keyin;
  assign timer_inc    = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      key_q      <= 1'b1;
      armed_q    <= 1'b0;
      single_evt <= 1'b0;
      double_evt <= 1'b0;
      long_evt   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      key_q      <= keyin;
      armed_q    <= armed_q | keyin;
      single_evt <= 1'b0;
      double_evt <= 1'b0;
      long_evt   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (press_edge) begin
            state_q <= StPress1;
            timer_q <= '0;
            busy    <= 1'b1;
          end
        end
        StPress1: begin
          // Reaching the long threshold wins over a release in the same cycle.
          if (timer_q == LongLast) begin
            long_evt <= 1'b1;
            if (release_edge) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StHold;
            end
          end else if (release_edge) begin
            state_q <= StWait2;
            timer_q <= '0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StHold: begin
          if (release_edge) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StWait2: begin
          // Timeout takes precedence; a press landing on the last cycle is dropped.
          if (timer_q == DblLast) begin
            single_evt <= 1'b1;
            state_q    <= StIdle;
            busy       <= 1'b0;
          end else if (press_edge) begin
            state_q <= StPress2;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StPress2: begin
          if (release_edge) begin
            double_evt <= 1'b1;
            state_q    <= StIdle;
            busy       <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_CLICK_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (single_evt | double_evt | long_evt) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign click_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder: a gesture-timing model fills per-cycle expected outputs.
module tb_key_click_decoder;

  localparam int LONG = 8;
  localparam int DBL  = 6;
  localparam int N    = 2048;

  logic clk = 1'b0;
  logic rst;
  logic keyin;
  logic single_evt;
  logic double_evt;
  logic long_evt;
  logic busy;
`ifdef KEY_CLICK_CNT_EN
  logic [15:0] click_cnt;
`endif

  key_click_decoder #(
    .LONG_CYC(LONG),
    .DBL_CYC (DBL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keyin     (keyin),
    .single_evt(single_evt),
    .double_evt(double_evt),
    .long_evt  (long_evt),
    .busy      (busy)
`ifdef KEY_CLICK_CNT_EN
    ,
    .click_cnt (click_cnt)
`endif
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far = index of the next rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit exp_s [N];
  bit exp_d [N];
  bit exp_l [N];
  bit exp_b [N];

  int total = 0;
  int bad   = 0;
  int n_s = 0, n_d = 0, n_l = 0;
  int last_s = -1, last_d = -1, last_l = -1;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // Outputs after rising edge k are checked at the following falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0 && cyc <= N) begin
        chk("single", int'(single_evt), int'(exp_s[cyc-1]));
        chk("double", int'(double_evt), int'(exp_d[cyc-1]));
        chk("long",   int'(long_evt),   int'(exp_l[cyc-1]));
        chk("busy",   int'(busy),       int'(exp_b[cyc-1]));
        if (single_evt === 1'b1) begin n_s++; last_s = cyc - 1; end
        if (double_evt === 1'b1) begin n_d++; last_d = cyc - 1; end
        if (long_evt === 1'b1)   begin n_l++; last_l = cyc - 1; end
      end
    end
  end

  // Called at a falling edge: value applies to edge index cyc.
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      keyin = v;
      @(negedge clk);
    end
  endtask

  // Press l1, then optionally gap g high and second press l2, then idle high.
  // Returns p, the edge index at which the first press is sampled.
  task automatic gesture(input int l1, input int g, input int l2, input int idle,
                         output int p);
    int r, e;
    p = cyc;
    if (l1 >= LONG) begin
      exp_l[p+LONG] = 1'b1;
      e = p + l1;
    end else begin
      r = p + l1;
      if (l2 == 0 || g >= DBL) begin
        e = r + DBL;
        exp_s[e] = 1'b1;
      end else begin
        e = r + g + l2;
        exp_d[e] = 1'b1;
      end
    end
    for (int c = p; c < e; c++) exp_b[c] = 1'b1;
    drive(1'b0, l1);
    if (l2 > 0) begin
      drive(1'b1, g);
      drive(1'b0, l2);
    end
    drive(1'b1, idle);
  endtask

  int p;
  int s0, d0, l0;

  initial begin
    rst   = 1'b1;
    keyin = 1'b1;
    @(negedge clk);
    drive(1'b1, 2);
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_evts", int'(single_evt | double_evt | long_evt), 0);
    drive(1'b1, 3);

    // Single click: press 3, release; single 6 after release edge.
    s0 = n_s; d0 = n_d; l0 = n_l;
    gesture(3, 0, 0, 12, p);
    chk("single_cycle", last_s, p + 9);
    chk("single_count", n_s - s0, 1);
    chk("single_noother", (n_d - d0) + (n_l - l0), 0);

    // Double click: press 3, gap 2, press 3.
    s0 = n_s; d0 = n_d;
    gesture(3, 2, 3, 12, p);
    chk("double_cycle", last_d, p + 8);
    chk("double_count", n_d - d0, 1);
    chk("double_nosingle", n_s - s0, 0);

    // Long press held 20 cycles.
    l0 = n_l; s0 = n_s;
    gesture(20, 0, 0, 12, p);
    chk("long_cycle", last_l, p + 8);
    chk("long_count", n_l - l0, 1);
    chk("long_nosingle", n_s - s0, 0);

    // Release coincides with long threshold: long wins.
    l0 = n_l;
    gesture(LONG, 0, 0, 12, p);
    chk("long_edge_cycle", last_l, p + 8);
    chk("long_edge_count", n_l - l0, 1);

    // One cycle shorter: short press, single.
    gesture(LONG - 1, 0, 0, 12, p);
    chk("short7_cycle", last_s, p + 13);

    // Widest gap still giving a double.
    gesture(2, DBL - 1, 2, 12, p);
    chk("gap5_double", last_d, p + 9);

    // Second press lands on the timeout cycle: single, press ignored.
    d0 = n_d; s0 = n_s;
    gesture(2, DBL, 2, 12, p);
    chk("gap6_single", last_s, p + 8);
    chk("gap6_count", (n_s - s0) * 10 + (n_d - d0), 10);

    // Long second press still yields double, no long.
    l0 = n_l;
    gesture(2, 1, 15, 12, p);
    chk("press2_long_double", last_d, p + 18);
    chk("press2_nolong", n_l - l0, 0);

    // Reset in WAIT2 suppresses the pending single.
    s0 = n_s;
    p = cyc;
    for (int c = p; c < p + 5; c++) exp_b[c] = 1'b1;
    drive(1'b0, 3);
    drive(1'b1, 2);
    rst = 1'b1;
    drive(1'b1, 1);
    rst = 1'b0;
    chk("rst_wait2_busy", int'(busy), 0);
    drive(1'b1, 12);
    chk("rst_wait2_noevt", n_s - s0, 0);

    // Key held low through reset: no press until it rises again.
    s0 = n_s; d0 = n_d; l0 = n_l;
    rst = 1'b1;
    drive(1'b0, 2);
    rst = 1'b0;
    drive(1'b0, 12);
    drive(1'b1, 10);
    chk("held_low_noevt", (n_s - s0) + (n_d - d0) + (n_l - l0), 0);

    // Normal operation afterwards.
    gesture(3, 0, 0, 12, p);
    chk("after_rst_single", last_s, p + 9);

`ifdef KEY_CLICK_CNT_EN
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    drive(1'b1, 2);
    gesture(3, 0, 0, 12, p);
    chk("cnt_wrap0", int'(click_cnt), 0);
    gesture(3, 0, 0, 12, p);
    chk("cnt_wrap1", int'(click_cnt), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
